// File: rtl/muldiv_pkg.sv
// Shared CPU definitions for the multiply/divide unit: MDop encodings and latencies.
package muldiv_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8
   } md_op_e;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   function automatic logic is_mul_div(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are captured at issue; the 64-bit result is formed from the captured
// operands and committed when the busy down-counter expires.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDop,
   input  logic        exc_flush,
   output logic        start,
   output logic        busy,
   output logic [31:0] MD_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_r;
   logic [3:0]  cnt;

   logic        is_mul;
   logic        is_sdiv;
   logic        div_zero;
   logic [63:0] prod;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [63:0] result;

   assign start = is_mul_div(MDop) && !exc_flush && !busy;

   // Read port for mfhi/mflo; reflects HI/LO even while an operation is running.
   always_comb begin
      MD_out = 32'd0;
      if (MDop == MD_MFHI)      MD_out = HI;
      else if (MDop == MD_MFLO) MD_out = LO;
   end

   // Result datapath from the captured operands. Signed division goes through
   // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with a zero remainder.
   always_comb begin
      is_mul   = (op_r == MD_MULT) || (op_r == MD_MULTU);
      is_sdiv  = (op_r == MD_DIV);
      div_zero = !is_mul && (op_b == 32'd0);
      if (op_r == MD_MULT)
         prod = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
      else
         prod = {32'd0, op_a} * {32'd0, op_b};
      neg_a  = is_sdiv && op_a[31];
      neg_b  = is_sdiv && op_b[31];
      mag_a  = neg_a ? -op_a : op_a;
      mag_b  = neg_b ? -op_b : op_b;
      uq     = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
      ur     = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
      quo    = (neg_a ^ neg_b) ? -uq : uq;
      rem    = neg_a ? -ur : ur;
      result = is_mul ? prod : {rem, quo};
   end

   // Issue, countdown, commit and mthi/mtlo writes; writes are ignored while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a <= 32'd0;
         op_b <= 32'd0;
         op_r <= 4'd0;
         cnt  <= 4'd0;
         busy <= 1'b0;
         HI   <= 32'd0;
         LO   <= 32'd0;
      end else if (start) begin
         op_a <= A;
         op_b <= B;
         op_r <= MDop;
         cnt  <= ((MDop == MD_MULT) || (MDop == MD_MULTU)) ? MULT_CYCLES : DIV_CYCLES;
         busy <= 1'b1;
      end else if (busy) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            busy <= 1'b0;
            if (!div_zero) begin
               HI <= result[63:32];
               LO <= result[31:0];
            end
         end
      end else if (!exc_flush) begin
         if (MDop == MD_MTHI) HI <= A;
         if (MDop == MD_MTLO) LO <= A;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected HI/LO queued at issue, popped when busy falls.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  MDop;
   logic        exc_flush;
   logic        start;
   logic        busy;
   logic [31:0] MD_out;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [63:0] sb_q[$];

   muldiv_unit dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .MDop(MDop), .exc_flush(exc_flush),
      .start(start), .busy(busy), .MD_out(MD_out), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
      longint sa, sb;
      logic [63:0] p;
      logic [31:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MD_MULT:  begin p = 64'(sa * sb); return p; end
         MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; return p; end
         MD_DIV: begin
            if (b == 32'd0) return {hi, lo};
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            return {r, q};
         end
         MD_DIVU: begin
            if (b == 32'd0) return {hi, lo};
            return {a % b, a / b};
         end
         default: return {hi, lo};
      endcase
   endfunction

   // Issue one op; optionally inject (inj_op, inj_a, inj_flush) during busy cycle n+inj_k.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_k, input logic [3:0] inj_op, input logic [31:0] inj_a, input logic inj_flush);
      int lat, cnt;
      logic [63:0] e;
      lat = ((op == MD_MULT) || (op == MD_MULTU)) ? 5 : 10;
      sb_q.push_back(model(op, a, b, m_hi, m_lo));
      MDop = op; A = a; B = b; exc_flush = 1'b0;
      #1;
      if (start !== 1'b1) begin $display("FAIL %s start: got %b want 1", name, start); n_bad++; end
      n_cmp++;
      cyc();
      MDop = MD_NONE; A = 32'd0; B = 32'd0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 30) begin
         cnt++;
         if (cnt == inj_k) begin
            MDop = inj_op; A = inj_a; exc_flush = inj_flush;
            #1;
            if (start !== 1'b0) begin $display("FAIL %s start_while_busy: got %b want 0", name, start); n_bad++; end
            n_cmp++;
         end
         cyc();
         MDop = MD_NONE; A = 32'd0; exc_flush = 1'b0;
      end
      if (cnt != lat) begin $display("FAIL %s busy_cycles: got %0d want %0d", name, cnt, lat); n_bad++; end
      n_cmp++;
      e = sb_q.pop_front();
      if (HI !== e[63:32]) begin $display("FAIL %s HI: got %h want %h", name, HI, e[63:32]); n_bad++; end
      n_cmp++;
      if (LO !== e[31:0]) begin $display("FAIL %s LO: got %h want %h", name, LO, e[31:0]); n_bad++; end
      n_cmp++;
      m_hi = e[63:32];
      m_lo = e[31:0];
   endtask

   task automatic test_reset();
      reset = 1'b1; MDop = MD_NONE; A = 32'd0; B = 32'd0; exc_flush = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
      #1;
      m_hi = 32'd0; m_lo = 32'd0;
      if (busy !== 1'b0) begin $display("FAIL reset busy: got %b want 0", busy); n_bad++; end
      n_cmp++;
      if (start !== 1'b0) begin $display("FAIL reset start: got %b want 0", start); n_bad++; end
      n_cmp++;
      if (MD_out !== 32'd0) begin $display("FAIL reset MD_out: got %h want 0", MD_out); n_bad++; end
      n_cmp++;
      if ({HI, LO} !== 64'd0) begin $display("FAIL reset HILO: got %h want 0", {HI, LO}); n_bad++; end
      n_cmp++;
   endtask

   task automatic test_mult();
      run_op("mult_neg2x3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, MD_NONE, 32'd0, 1'b0);
      if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin $display("FAIL mult_const: got %h want FFFFFFFFFFFFFFFA", {HI, LO}); n_bad++; end
      n_cmp++;
      run_op("multu_neg2x3", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 0, MD_NONE, 32'd0, 1'b0);
      if ({HI, LO} !== 64'h0000_0002_FFFF_FFFA) begin $display("FAIL multu_const: got %h want 00000002FFFFFFFA", {HI, LO}); n_bad++; end
      n_cmp++;
      for (int i = 0; i < 4; i++)
         run_op("mult_rand", (i[0] ? MD_MULTU : MD_MULT), $urandom, $urandom, 0, MD_NONE, 32'd0, 1'b0);
   endtask

   task automatic test_div();
      run_op("div_neg7by2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, MD_NONE, 32'd0, 1'b0);
      if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin $display("FAIL div_const: got %h want FFFFFFFFFFFFFFFD", {HI, LO}); n_bad++; end
      n_cmp++;
      run_op("divu_by0", MD_DIVU, 32'd7, 32'd0, 0, MD_NONE, 32'd0, 1'b0);
      if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin $display("FAIL divu_by0_unchanged: got %h", {HI, LO}); n_bad++; end
      n_cmp++;
      run_op("div_by0", MD_DIV, 32'd9, 32'd0, 0, MD_NONE, 32'd0, 1'b0);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, MD_NONE, 32'd0, 1'b0);
      if ({HI, LO} !== 64'h0000_0000_8000_0000) begin $display("FAIL div_ovf_const: got %h want 0000000080000000", {HI, LO}); n_bad++; end
      n_cmp++;
      run_op("div_7byneg2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 0, MD_NONE, 32'd0, 1'b0);
      run_op("divu_big", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 0, MD_NONE, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++)
         run_op("div_rand", (i[0] ? MD_DIVU : MD_DIV), $urandom, $urandom_range(1, 100000), 0, MD_NONE, 32'd0, 1'b0);
   endtask

   task automatic test_mt();
      MDop = MD_MTHI; A = 32'h1234_5678;
      cyc();
      m_hi = 32'h1234_5678;
      MDop = MD_MFLO; A = 32'd0;
      #1;
      if (MD_out !== m_lo) begin $display("FAIL mflo_after_mthi: got %h want %h", MD_out, m_lo); n_bad++; end
      n_cmp++;
      cyc();
      MDop = MD_MFHI;
      #1;
      if (MD_out !== 32'h1234_5678) begin $display("FAIL mfhi_after_mthi: got %h want 12345678", MD_out); n_bad++; end
      n_cmp++;
      cyc();
      MDop = MD_MTLO; A = 32'hCAFE_0001; exc_flush = 1'b1;
      cyc();
      MDop = MD_MTLO; A = 32'h0BAD_F00D; exc_flush = 1'b0;
      cyc();
      m_lo = 32'h0BAD_F00D;
      MDop = 4'd12;
      #1;
      if (MD_out !== 32'd0) begin $display("FAIL mdout_op12: got %h want 0", MD_out); n_bad++; end
      n_cmp++;
      if (LO !== m_lo) begin $display("FAIL mtlo_flush_then_write: got %h want %h", LO, m_lo); n_bad++; end
      n_cmp++;
      MDop = MD_NONE;
   endtask

   task automatic test_flush();
      MDop = MD_MULT; A = 32'd11; B = 32'd13; exc_flush = 1'b1;
      #1;
      if (start !== 1'b0) begin $display("FAIL flush_start: got %b want 0", start); n_bad++; end
      n_cmp++;
      cyc();
      MDop = MD_NONE; exc_flush = 1'b0;
      #1;
      if (busy !== 1'b0) begin $display("FAIL flush_busy: got %b want 0", busy); n_bad++; end
      n_cmp++;
      cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
      if ({HI, LO} !== {m_hi, m_lo}) begin $display("FAIL flush_hilo: got %h want %h", {HI, LO}, {m_hi, m_lo}); n_bad++; end
      n_cmp++;
      run_op("div_flush_mid", MD_DIV, 32'd100, 32'd7, 2, MD_NONE, 32'd0, 1'b1);
   endtask

   task automatic test_reset_mid();
      MDop = MD_MULT; A = 32'd5; B = 32'd5;
      cyc();
      MDop = MD_NONE;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      sb_q.delete();
      m_hi = 32'd0; m_lo = 32'd0;
      if (busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", busy); n_bad++; end
      n_cmp++;
      if ({HI, LO} !== 64'd0) begin $display("FAIL rstmid_hilo: got %h want 0", {HI, LO}); n_bad++; end
      n_cmp++;
      for (int i = 0; i < 8; i++) cyc();
      if ({HI, LO} !== 64'd0) begin $display("FAIL rstmid_no_commit: got %h want 0", {HI, LO}); n_bad++; end
      n_cmp++;
   endtask

   task automatic test_busy_ignore();
      run_op("mult_mtlo_ignored", MD_MULT, 32'd2, 32'd3, 2, MD_MTLO, 32'h0000_00AA, 1'b0);
      if ({HI, LO} !== 64'd6) begin $display("FAIL mtlo_ignored: got %h want 6", {HI, LO}); n_bad++; end
      n_cmp++;
      run_op("div_mult_ignored", MD_DIVU, 32'd50, 32'd8, 4, MD_MULT, 32'h0000_0009, 1'b0);
      run_op("mult_mthi_ignored", MD_MULTU, 32'd9, 32'd9, 5, MD_MTHI, 32'hDEAD_BEEF, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_1", MD_MULT, 32'h8000_0000, 32'h8000_0000, 0, MD_NONE, 32'd0, 1'b0);
      run_op("b2b_2", MD_DIV, 32'hFFFF_FF9C, 32'd7, 0, MD_NONE, 32'd0, 1'b0);
      run_op("b2b_3", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, MD_NONE, 32'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mt();
      test_flush();
      test_reset_mid();
      test_busy_ignore();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
